// File: rtl/sram_axi_bridge.sv
// -----------------------------------------------------------------------------
// sram_axi_bridge
//
// Purpose:
//   Converts the CPU core's instruction-side and data-side SRAM-style requests
//   (req / addr_ok / data_ok handshake) into single-beat AXI3 transactions.
//   Exactly one transaction is outstanding at any time. When both sides request
//   in the same IDLE cycle, the data side wins.
//
// Optional build macro:
//   SRAM_AXI_ADDR_MAP_EN - when defined, addresses in 0x8000_0000..0xBFFF_FFFF
//                          (kseg0/kseg1) are driven on AXI as {3'b000, addr[28:0]};
//                          when undefined, addresses pass through unchanged.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   inst_req/inst_addr        fetch request in
//   inst_addr_ok              fetch accepted this cycle (combinational, IDLE only)
//   inst_data_ok/inst_rdata   one-cycle fetch completion pulse and fetched word
//   data_req/wr/size/wstrb/addr/wdata   load/store request in
//   data_addr_ok              data request accepted this cycle
//   data_data_ok/data_rdata   one-cycle load/store completion pulse, loaded word
//   ar*, r*                   AXI read address / read data channels
//   aw*, w*, b*               AXI write address / write data / write response
// -----------------------------------------------------------------------------
module sram_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // latched request
  logic        r_owner_data;   // 1 = data side owns the outstanding transaction
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;

  // per-channel handshake completion inside WR_ADDR
  logic        r_aw_done;
  logic        r_w_done;

  // completion outputs
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic        r_inst_data_ok;
  logic        r_data_data_ok;

  logic        w_rd_done;
  logic        w_wr_done;
  logic [31:0] w_bus_addr;

  // rid carries no information with a single outstanding transaction.
  logic        w_unused;
  assign w_unused = ^rid;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake outputs. Everything is forced low while rst is
  // high so no AXI handshake or CPU acceptance can complete in a reset cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    w_rd_done    = 1'b0;
    w_wr_done    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (data_req) begin
            data_addr_ok = 1'b1;
            w_state_next = data_wr ? S_WR_ADDR : S_RD_ADDR;
          end else if (inst_req) begin
            inst_addr_ok = 1'b1;
            w_state_next = S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          arvalid = 1'b1;
          if (arready) begin
            w_state_next = S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          rready = 1'b1;
          if (rvalid) begin
            w_rd_done    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        S_WR_ADDR: begin
          // address and data channels complete independently
          awvalid = !r_aw_done;
          wvalid  = !r_w_done;
          if ((r_aw_done || awready) && (r_w_done || wready)) begin
            w_state_next = S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          bready = 1'b1;
          if (bvalid) begin
            w_wr_done    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch, write-channel progress and completion registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_data   <= 1'b0;
      r_addr         <= 32'd0;
      r_size         <= 2'd0;
      r_wstrb        <= 4'd0;
      r_wdata        <= 32'd0;
      r_aw_done      <= 1'b0;
      r_w_done       <= 1'b0;
      r_inst_rdata   <= 32'd0;
      r_data_rdata   <= 32'd0;
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
    end else begin
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;

      if (data_addr_ok) begin
        r_owner_data <= 1'b1;
        r_addr       <= data_addr;
        r_size       <= data_size;
        r_wstrb      <= data_wstrb;
        r_wdata      <= data_wdata;
        r_aw_done    <= 1'b0;
        r_w_done     <= 1'b0;
      end else if (inst_addr_ok) begin
        r_owner_data <= 1'b0;
        r_addr       <= inst_addr;
        r_size       <= 2'd2;
      end

      if (awvalid && awready) begin
        r_aw_done <= 1'b1;
      end
      if (wvalid && wready) begin
        r_w_done <= 1'b1;
      end

      if (w_rd_done) begin
        if (r_owner_data) begin
          r_data_rdata   <= rdata;
          r_data_data_ok <= 1'b1;
        end else begin
          r_inst_rdata   <= rdata;
          r_inst_data_ok <= 1'b1;
        end
      end

      if (w_wr_done) begin
        r_data_data_ok <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Address presented on the bus
  // ---------------------------------------------------------------------------
`ifdef SRAM_AXI_ADDR_MAP_EN
  // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space
  assign w_bus_addr = (r_addr[31:30] == 2'b10) ? {3'b000, r_addr[28:0]} : r_addr;
`else
  assign w_bus_addr = r_addr;
`endif

  // Channel payloads come straight from the latch, so they are stable for the
  // whole time the matching valid is high.
  assign arid   = r_owner_data ? ID_DATA : ID_INST;
  assign araddr = w_bus_addr;
  assign arsize = {1'b0, r_size};

  assign awid   = r_owner_data ? ID_DATA : ID_INST;
  assign awaddr = w_bus_addr;
  assign awsize = {1'b0, r_size};
  assign wdata  = r_wdata;
  assign wstrb  = r_wstrb;

  assign inst_rdata   = r_inst_rdata;
  assign inst_data_ok = r_inst_data_ok;
  assign data_rdata   = r_data_rdata;
  assign data_data_ok = r_data_data_ok;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_axi_bridge
//
// Self-checking bench for sram_axi_bridge. The bench plays both the CPU and
// the AXI slave from one thread; each transaction's expected bus fields and
// completion timing are derived from the request itself (owner, address map,
// size), and a two-word model tracks the last word delivered to each side.
// -----------------------------------------------------------------------------
module tb_sram_axi_bridge;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  sram_axi_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .arid         (arid),
    .araddr       (araddr),
    .arsize       (arsize),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rready       (rready),
    .awid         (awid),
    .awaddr       (awaddr),
    .awsize       (awsize),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .wvalid       (wvalid),
    .wready       (wready),
    .bvalid       (bvalid),
    .bready       (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_inst_rdata = 32'd0;
  logic [31:0] last_data_rdata = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are driven 2 time units after a rising edge; outputs are sampled
  // 1 unit later, well clear of both clock edges.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] bus_addr(input logic [31:0] a);
`ifdef SRAM_AXI_ADDR_MAP_EN
    if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a & 32'h1FFF_FFFF;
`endif
    return a;
  endfunction

  // Present one request in an IDLE cycle and confirm only its side is accepted.
  task automatic accept(input bit is_data, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        input bit hold_inst, input logic [31:0] iaddr);
    data_req   = is_data;
    data_wr    = wr;
    data_size  = size;
    data_addr  = addr;
    data_wdata = wd;
    data_wstrb = ws;
    inst_req   = !is_data || hold_inst;
    inst_addr  = is_data ? iaddr : addr;
    #1;
    check_eq("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, is_data});
    check_eq("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, !is_data});
    step();
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_addr  = $urandom;
    data_wdata = $urandom;
    inst_req   = hold_inst;
  endtask

  // Slave side of a read: ar accepted after ar_dly wait cycles, r returned
  // after r_dly more. Ends in the completion cycle, already sampled.
  task automatic read_phase(input bit own_data, input logic [31:0] addr, input logic [2:0] exp_size,
                            input int ar_dly, input int r_dly, input logic [31:0] val);
    logic [31:0] ea;
    logic [3:0]  eid;
    ea  = bus_addr(addr);
    eid = own_data ? 4'd1 : 4'd0;
    for (int k = 0; k <= ar_dly; k++) begin
      arready = (k == ar_dly);
      #1;
      check_eq("arvalid", {31'd0, arvalid}, 32'd1);
      check_eq("araddr", araddr, ea);
      check_eq("arid", {28'd0, arid}, {28'd0, eid});
      check_eq("arsize", {29'd0, arsize}, {29'd0, exp_size});
      check_eq("busy_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd0);
      check_eq("rready_early", {31'd0, rready}, 32'd0);
      step();
    end
    arready = 1'b0;
    for (int k = 0; k <= r_dly; k++) begin
      rvalid = (k == r_dly);
      rdata  = (k == r_dly) ? val : $urandom;
      rid    = eid;
      #1;
      check_eq("rready", {31'd0, rready}, 32'd1);
      check_eq("arvalid_after", {31'd0, arvalid}, 32'd0);
      check_eq("busy_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd0);
      check_eq("early_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
      step();
    end
    rvalid = 1'b0;
    rdata  = $urandom;
    #1;
    if (own_data) last_data_rdata = val;
    else          last_inst_rdata = val;
    check_eq("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, !own_data});
    check_eq("data_data_ok", {31'd0, data_data_ok}, {31'd0, own_data});
    check_eq("inst_rdata", inst_rdata, last_inst_rdata);
    check_eq("data_rdata", data_rdata, last_data_rdata);
    check_eq("rready_done", {31'd0, rready}, 32'd0);
  endtask

  // Slave side of a store: awready after aw_dly, wready after w_dly, bvalid
  // after b_dly. Ends in the completion cycle, already sampled.
  task automatic write_phase(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wd, input logic [3:0] ws,
                             input int aw_dly, input int w_dly, input int b_dly);
    int n;
    n = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int k = 0; k <= n; k++) begin
      awready = (k == aw_dly);
      wready  = (k == w_dly);
      #1;
      check_eq("awvalid", {31'd0, awvalid}, {31'd0, k <= aw_dly});
      check_eq("wvalid", {31'd0, wvalid}, {31'd0, k <= w_dly});
      if (k <= aw_dly) begin
        check_eq("awaddr", awaddr, bus_addr(addr));
        check_eq("awsize", {29'd0, awsize}, {29'd0, 1'b0, size});
        check_eq("awid", {28'd0, awid}, 32'd1);
      end
      if (k <= w_dly) begin
        check_eq("wdata", wdata, wd);
        check_eq("wstrb", {28'd0, wstrb}, {28'd0, ws});
      end
      check_eq("wr_arvalid", {31'd0, arvalid}, 32'd0);
      check_eq("early_bready", {31'd0, bready}, 32'd0);
      check_eq("busy_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd0);
      step();
    end
    awready = 1'b0;
    wready  = 1'b0;
    for (int k = 0; k <= b_dly; k++) begin
      bvalid = (k == b_dly);
      #1;
      check_eq("bready", {31'd0, bready}, 32'd1);
      check_eq("aw_w_dropped", {30'd0, awvalid, wvalid}, 32'd0);
      check_eq("early_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
      step();
    end
    bvalid = 1'b0;
    #1;
    check_eq("store_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd2);
    check_eq("inst_rdata_kept", inst_rdata, last_inst_rdata);
    check_eq("data_rdata_kept", data_rdata, last_data_rdata);
  endtask

  // One quiet cycle: completion pulses must have ended, bus idle.
  task automatic idle_check();
    step();
    #1;
    check_eq("pulse_end", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
    check_eq("idle_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    bit          is_data;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] wd;
    logic [3:0]  ws;

    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    check_eq("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
    check_eq("rst_inst_rdata", inst_rdata, 32'd0);
    check_eq("rst_data_rdata", data_rdata, 32'd0);
    check_eq("rst_araddr", araddr, 32'd0);
    check_eq("rst_awaddr", awaddr, 32'd0);
    check_eq("rst_wdata", wdata, 32'd0);
    check_eq("rst_wstrb", {28'd0, wstrb}, 32'd0);
    check_eq("rst_ids", {24'd0, arid, awid}, 32'd0);
    $display("txn reset: outputs checked");

    // fetch, zero-wait slave: completion exactly three cycles after accept
    accept(0, 0, 2'd2, 32'hBFC0_0000, 32'd0, 4'd0, 0, 32'd0);
    read_phase(0, 32'hBFC0_0000, 3'b010, 0, 0, 32'h3C08_0001);
    idle_check();
    $display("txn fetch: addr=bfc00000 rdata=3c080001");

    // simultaneous requests: data wins, inst taken on completion cycle
    accept(1, 0, 2'd2, 32'h8000_0010, 32'd0, 4'd0, 1, 32'hBFC0_0004);
    read_phase(1, 32'h8000_0010, 3'b010, 0, 0, 32'hCAFE_0010);
    check_eq("inst_accept_after", {30'd0, data_addr_ok, inst_addr_ok}, 32'd1);
    step();
    inst_req = 1'b0;
    read_phase(0, 32'hBFC0_0004, 3'b010, 0, 1, 32'h2402_0007);
    idle_check();
    $display("txn simultaneous: data 80000010 then inst bfc00004");

    // store with awready two cycles ahead of wready
    accept(1, 1, 2'd2, 32'h0000_0104, 32'h1234_5678, 4'b0011, 0, 32'd0);
    write_phase(32'h0000_0104, 2'd2, 32'h1234_5678, 4'b0011, 0, 2, 1);
    idle_check();
    $display("txn store: addr=00000104 wdata=12345678 wstrb=3");

    // byte load
    accept(1, 0, 2'd0, 32'h0000_0003, 32'd0, 4'd0, 0, 32'd0);
    read_phase(1, 32'h0000_0003, 3'b000, 0, 0, 32'h0000_00A5);
    idle_check();
    $display("txn byte load: addr=00000003");

    // arready backpressure with a pending fetch that must wait
    accept(1, 0, 2'd1, 32'hA000_0020, 32'd0, 4'd0, 1, 32'h0040_0000);
    read_phase(1, 32'hA000_0020, 3'b001, 5, 2, 32'h5555_AAAA);
    check_eq("inst_accept_after", {30'd0, data_addr_ok, inst_addr_ok}, 32'd1);
    step();
    inst_req = 1'b0;
    read_phase(0, 32'h0040_0000, 3'b010, 1, 0, 32'h0BAD_F00D);
    idle_check();
    $display("txn backpressure: arready after 5 cycles");

    // randomized back-to-back traffic
    for (int i = 0; i < 40; i++) begin
      is_data = ($urandom_range(0, 2) != 0);
      wr      = is_data && ($urandom_range(0, 1) == 1);
      sz      = is_data ? 2'($urandom_range(0, 2)) : 2'd2;
      case ($urandom_range(0, 3))
        0:       a = {4'h0, 28'($urandom)};
        1:       a = {3'b100, 29'($urandom)};
        2:       a = {3'b101, 29'($urandom)};
        default: a = $urandom;
      endcase
      wd = $urandom;
      ws = 4'($urandom);
      v  = $urandom;
      accept(is_data, wr, sz, a, wd, ws, 0, 32'd0);
      if (wr) begin
        write_phase(a, sz, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        $display("txn rand %0d: store addr=%08h size=%0d wdata=%08h wstrb=%h", i, a, sz, wd, ws);
      end else begin
        read_phase(is_data, a, {1'b0, sz}, $urandom_range(0, 3), $urandom_range(0, 3), v);
        $display("txn rand %0d: %s addr=%08h size=%0d rdata=%08h", i, is_data ? "load" : "fetch", a, sz, v);
      end
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    // reset while waiting for rvalid: transaction abandoned, late rvalid ignored
    accept(1, 0, 2'd2, 32'h0000_0200, 32'd0, 4'd0, 0, 32'd0);
    arready = 1'b1;
    #1;
    check_eq("rst_test_arvalid", {31'd0, arvalid}, 32'd1);
    step();
    arready = 1'b0;
    #1;
    check_eq("rst_test_rready", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_inst_rdata = 32'd0;
    last_data_rdata = 32'd0;
    #1;
    check_eq("post_rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    check_eq("post_rst_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    step();
    rvalid = 1'b0;
    #1;
    check_eq("late_rvalid_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
    check_eq("late_rvalid_rdata", data_rdata, 32'd0);
    check_eq("late_rvalid_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    idle_check();
    $display("txn reset mid-read: abandoned");

    // recovery
    accept(0, 0, 2'd2, 32'h9FC0_0010, 32'd0, 4'd0, 0, 32'd0);
    read_phase(0, 32'h9FC0_0010, 3'b010, 0, 0, 32'h1111_2222);
    idle_check();
    $display("txn recovery fetch: addr=9fc00010");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core's instruction-SRAM and data-SRAM request ports.
- Converts them into single-beat AXI3 read/write transactions toward the SoC interconnect.
- Arbitrates between the instruction and data sides and keeps one outstanding transaction at a time.
- Uses an addr_ok/data_ok handshake on the CPU side so the core pipeline can stall on bus latency.

Parameters:
- ID_INST, 4'd0, AXI ID driven for instruction fetches.
- ID_DATA, 4'd1, AXI ID driven for data accesses.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid, one-cycle pulse
- inst_rdata  out  32  fetched word
- data_req  in  1  load/store request
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  store byte enables
- data_addr  in  32  load/store address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data / store completion, one-cycle pulse
- data_rdata  out  32  loaded word
- arid/araddr/arsize/arvalid  out  4/32/3/1  AXI read address channel
- arready  in  1
- rid/rdata/rvalid  in  4/32/1  AXI read data channel
- rready  out  1
- awid/awaddr/awsize/awvalid  out  4/32/3/1  AXI write address channel
- awready  in  1
- wdata/wstrb/wvalid  out  32/4/1  AXI write data channel
- wready  in  1
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset: state IDLE. All valid/ready/ok outputs 0. inst_rdata, data_rdata, araddr, awaddr, wdata, wstrb = 0. IDs = 0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE arbitration, data has priority:
  - data_req=1: data_addr_ok=1 combinationally in the same cycle. Latch owner=DATA, address, size, wr, wstrb, wdata. Next state WR_ADDR if data_wr, else RD_ADDR.
  - data_req=0 and inst_req=1: inst_addr_ok=1. Latch owner=INST, size=2. Next state RD_ADDR.
  - addr_ok is never asserted outside IDLE.
  - Both addr_ok signals are never high in the same cycle.
- RD_ADDR:
  - arvalid=1 with latched address; arsize = {1'b0, size}; arid per owner.
  - arvalid holds until arready; transition to RD_DATA on the cycle arvalid & arready.
  - araddr and arid stay stable while arvalid=1.
- RD_DATA:
  - rready=1.
  - On rvalid: capture rdata into the owner's rdata register, go to IDLE.
  - The owner's data_ok is high for exactly the next cycle; rdata is valid in that cycle and held until the owner's next capture.
  - rid is not checked; the single outstanding transaction makes the owner unambiguous.
- WR_ADDR:
  - awvalid=1 and wvalid=1 asserted together.
  - Each drops independently after its own handshake (awready / wready may arrive in any order or the same cycle).
  - When both handshakes are done, go to WR_RESP.
  - wstrb = latched data_wstrb, passed through unmodified.
- WR_RESP:
  - bready=1. On bvalid: go to IDLE; data_data_ok is high for exactly the next cycle.
  - bresp is ignored.
- A new request may be accepted in IDLE in the same cycle a data_ok pulse is being output.
- Latency with zero-wait AXI (arready/rvalid immediate): addr_ok at T, arvalid T+1, rvalid T+2, data_ok T+3.
- Reset mid-transaction: return to IDLE next cycle, drop every valid/ready, emit no data_ok, abandon the pending transaction.
- Requests arriving while busy are not acknowledged; the CPU holds req and address stable until addr_ok.

Optional Feature:
- Macro: SRAM_AXI_ADDR_MAP_EN.
- Defined: kseg0/kseg1 fixed mapping on the latched address. Addresses 0x8000_0000–0xBFFF_FFFF are driven as {3'b000, addr[28:0]}; all others pass unchanged.
- Undefined: addresses pass through unmodified, and the core performs the mapping.

Test Plan:
- Fetch: inst_req, inst_addr=0xBFC0_0000, zero-wait AXI returning rdata=0x3C08_0001 -> arid=0, araddr=0xBFC0_0000 (0x1FC0_0000 with map), inst_data_ok one pulse at T+3, inst_rdata=0x3C08_0001.
- Simultaneous requests: inst_req and data_req (load 0x8000_0010, size=2) in the same cycle -> data_addr_ok=1, inst_addr_ok=0, arid=1; inst accepted in the first IDLE after data_data_ok.
- Store, awready 2 cycles before wready: data_wr=1, addr 0x0000_0104, wstrb=4'b0011, wdata=0x1234_5678 -> awvalid drops first, wvalid holds until wready, bready=1 afterwards, data_data_ok one pulse after bvalid.
- Byte load: data_size=0, addr 0x0000_0003 -> arsize=3'b000, araddr=0x0000_0003.
- Backpressure: arready delayed 5 cycles -> arvalid and araddr stable throughout, no addr_ok to the other requester during the wait.
- Reset asserted in RD_DATA before rvalid -> next cycle IDLE, rready=0, no data_ok; a later rvalid is ignored.
